// File: rtl/regfile_mp.sv
// Multi-port register file: one byte-enabled write port, two registered read ports,
// and a hardware clear sweep that runs after reset or on request.
module regfile_mp #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter bit BYPASS = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear_req,
  output logic                ready,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en_a,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  output logic [DATA_W-1:0]   rd_data_a,
  output logic                rd_valid_a,
  input  logic                rd_en_b,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [DATA_W-1:0]   rd_data_b,
  output logic                rd_valid_b
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic              accept;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_in_range, wr_fire;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_next_a, rd_next_b;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [BYTES-1:0]  be
  );
    logic [DATA_W-1:0] w;
    w = old_word;
    for (int k = 0; k < BYTES; k++) begin
      if (be[k]) w[8*k +: 8] = new_word[8*k +: 8];
    end
    return w;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // accept marks a READY cycle in which user reads and writes take effect.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    ready      = 1'b0;
    accept     = 1'b0;
    case (state)
      CLEAR: begin
        ptr_next = ptr + ADDR_W'(1);
        if (ptr == LAST_PTR) begin
          state_next = READY;
          ptr_next   = '0;
        end
      end
      READY: begin
        ready = 1'b1;
        if (clear_req) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end else begin
          accept = 1'b1;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
  assign wr_fire     = accept && wr_en && wr_in_range;
  assign wr_idx      = wr_addr[IDX_W-1:0];
  assign wr_word     = merge_bytes(mem[wr_idx], wr_data, wr_be);

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[ptr[IDX_W-1:0]] <= '0;
      end else if (wr_fire) begin
        mem[wr_idx] <= wr_word;
      end
    end
  end

  // Out-of-range reads return zero; a same-cycle write hit forwards the merged word.
  always_comb begin
    rd_next_a = '0;
    if ({1'b0, rd_addr_a} < DEPTH_L) begin
      rd_next_a = mem[rd_addr_a[IDX_W-1:0]];
      if (BYPASS && wr_fire && (wr_addr == rd_addr_a)) rd_next_a = wr_word;
    end
  end

  always_comb begin
    rd_next_b = '0;
    if ({1'b0, rd_addr_b} < DEPTH_L) begin
      rd_next_b = mem[rd_addr_b[IDX_W-1:0]];
      if (BYPASS && wr_fire && (wr_addr == rd_addr_b)) rd_next_b = wr_word;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid_a <= 1'b0;
      rd_valid_b <= 1'b0;
      rd_data_a  <= '0;
      rd_data_b  <= '0;
    end else begin
      rd_valid_a <= accept && rd_en_a;
      rd_valid_b <= accept && rd_en_b;
      if (accept && rd_en_a) rd_data_a <= rd_next_a;
      if (accept && rd_en_b) rd_data_b <= rd_next_b;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised scoreboard bench for regfile_mp: a forwarding and a non-forwarding
// instance share one stimulus stream and are checked against an array-based model.
module tb_regfile_mp;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 7;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              clear_req = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [1:0]        wr_be = '0;
  logic [15:0]       wr_data = '0;
  logic              rd_en_a = 1'b0;
  logic [ADDR_W-1:0] rd_addr_a = '0;
  logic              rd_en_b = 1'b0;
  logic [ADDR_W-1:0] rd_addr_b = '0;

  logic        ready_byp, ready_nob;
  logic [15:0] rd_data_a_byp, rd_data_b_byp, rd_data_a_nob, rd_data_b_nob;
  logic        rd_valid_a_byp, rd_valid_b_byp, rd_valid_a_nob, rd_valid_b_nob;

  always #5 clock = ~clock;

  regfile_mp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYPASS(1'b1)) dut_byp (
    .clock(clock), .reset(reset), .clear_req(clear_req), .ready(ready_byp),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a_byp), .rd_valid_a(rd_valid_a_byp),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b_byp), .rd_valid_b(rd_valid_b_byp)
  );

  regfile_mp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYPASS(1'b0)) dut_nob (
    .clock(clock), .reset(reset), .clear_req(clear_req), .ready(ready_nob),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a_nob), .rd_valid_a(rd_valid_a_nob),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b_nob), .rd_valid_b(rd_valid_b_nob)
  );

  // One entry per cycle with reads; index 0..3 = A/B forwarding, A/B non-forwarding.
  typedef struct {
    int               due;
    logic [3:0]       en;
    logic [3:0][15:0] data;
  } exp_t;

  exp_t             exp_q[$];
  logic [15:0]      model_mem [DEPTH];
  logic [3:0][15:0] last_data = '0;
  int               sweep_left = DEPTH;
  logic             exp_ready = 1'b0;
  int               cycle = 0;
  int               compared = 0;
  int               mismatched = 0;

  always @(posedge clock) cycle <= cycle + 1;

  function automatic string portName(input int p);
    case (p)
      0:       return "rd_a_byp";
      1:       return "rd_b_byp";
      2:       return "rd_a_nob";
      default: return "rd_b_nob";
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  function automatic logic [15:0] readExp(input logic [6:0] ra, input logic fwd,
                                          input logic wr_hit_ok, input logic [6:0] wa,
                                          input logic [15:0] merged);
    if (int'(ra) >= DEPTH) return 16'h0000;
    if (fwd && wr_hit_ok && (wa == ra)) return merged;
    return model_mem[int'(ra)];
  endfunction

  // Drives one clock's worth of inputs and advances the model across the coming edge.
  task automatic applyStimulus(input logic rst, input logic clr, input logic we,
                               input logic [6:0] wa, input logic [1:0] be, input logic [15:0] wd,
                               input logic rea, input logic [6:0] raa,
                               input logic reb, input logic [6:0] rab);
    exp_t        e;
    logic        wr_ok;
    logic [15:0] merged;
    @(negedge clock);
    #1;
    reset = rst; clear_req = clr; wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
    rd_en_a = rea; rd_addr_a = raa; rd_en_b = reb; rd_addr_b = rab;
    if (rst) begin
      sweep_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h0000;
      last_data = '0;
    end else if (sweep_left > 0) begin
      sweep_left--;
    end else if (clr) begin
      sweep_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h0000;
    end else begin
      wr_ok  = we && (int'(wa) < DEPTH);
      merged = 16'h0000;
      if (wr_ok) begin
        merged = model_mem[int'(wa)];
        for (int k = 0; k < 2; k++) if (be[k]) merged[8*k +: 8] = wd[8*k +: 8];
      end
      e.due  = cycle + 1;
      e.en   = {reb, rea, reb, rea};
      e.data = '0;
      e.data[0] = readExp(raa, 1'b1, wr_ok, wa, merged);
      e.data[1] = readExp(rab, 1'b1, wr_ok, wa, merged);
      e.data[2] = readExp(raa, 1'b0, wr_ok, wa, merged);
      e.data[3] = readExp(rab, 1'b0, wr_ok, wa, merged);
      if (e.en != 4'b0000) exp_q.push_back(e);
      if (wr_ok) model_mem[int'(wa)] = merged;
    end
    exp_ready = (sweep_left == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'b00, 16'h0, 1'b0, 7'd0, 1'b0, 7'd0);
  endtask

  task automatic readAll();
    for (int i = 0; i < DEPTH + 16; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'b00, 16'h0, 1'b1, 7'(i), 1'b1, 7'(DEPTH + 15 - i));
  endtask

  function automatic logic [6:0] randAddr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return 7'($urandom_range(0, 7));
    if (r < 9) return 7'($urandom_range(0, DEPTH - 1));
    return 7'($urandom_range(DEPTH, 127));
  endfunction

  always @(negedge clock) begin : monitor
    logic [3:0]       got_v;
    logic [3:0][15:0] got_d;
    exp_t             e;
    got_v = {rd_valid_b_nob, rd_valid_a_nob, rd_valid_b_byp, rd_valid_a_byp};
    got_d = {rd_data_b_nob, rd_data_a_nob, rd_data_b_byp, rd_data_a_byp};
    checkOutput("ready_byp", {15'd0, ready_byp}, {15'd0, exp_ready});
    checkOutput("ready_nob", {15'd0, ready_nob}, {15'd0, exp_ready});
    e.due = -1; e.en = '0; e.data = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cycle) e = exp_q.pop_front();
    for (int p = 0; p < 4; p++) begin
      checkOutput({portName(p), " valid"}, {15'd0, got_v[p]}, {15'd0, e.en[p]});
      if (e.en[p]) last_data[p] = e.data[p];
      checkOutput({portName(p), " data"}, got_d[p], last_data[p]);
    end
  end

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 2'b00, 16'h0, 1'b0, 7'd0, 1'b0, 7'd0);
    checkOutput("reset ready", {15'd0, ready_byp}, 16'd0);
    checkOutput("reset rd_valid_a", {15'd0, rd_valid_a_byp}, 16'd0);
    checkOutput("reset rd_data_a", rd_data_a_byp, 16'h0000);
    checkOutput("reset rd_data_b", rd_data_b_nob, 16'h0000);

    idle(DEPTH);
    readAll();

    applyStimulus(1'b0, 1'b0, 1'b1, 7'd5, 2'b11, 16'hBEEF, 1'b0, 7'd0, 1'b0, 7'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'b00, 16'h0, 1'b1, 7'd5, 1'b0, 7'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 7'd5, 2'b01, 16'h1234, 1'b0, 7'd0, 1'b0, 7'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'b00, 16'h0, 1'b1, 7'd5, 1'b0, 7'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 7'd5, 2'b00, 16'hFFFF, 1'b0, 7'd0, 1'b0, 7'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'b00, 16'h0, 1'b1, 7'd5, 1'b1, 7'd5);

    applyStimulus(1'b0, 1'b0, 1'b1, 7'd9, 2'b11, 16'h5555, 1'b0, 7'd0, 1'b0, 7'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 7'd9, 2'b11, 16'hAAAA, 1'b1, 7'd9, 1'b1, 7'd9);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'b00, 16'h0, 1'b1, 7'd9, 1'b1, 7'd9);

    applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 2'b00, 16'h0, 1'b0, 7'd0, 1'b0, 7'd0);
    idle(30);
    applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 2'b00, 16'h0, 1'b0, 7'd0, 1'b0, 7'd0);
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, randAddr(), 2'b11, 16'($urandom), 1'b1, randAddr(), 1'b1, randAddr());
    idle(sweep_left);
    readAll();

    applyStimulus(1'b0, 1'b0, 1'b1, 7'd63, 2'b11, 16'h1357, 1'b0, 7'd0, 1'b0, 7'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 7'd7, 2'b11, 16'h2468, 1'b1, 7'd63, 1'b0, 7'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 7'd8, 2'b11, 16'h9999, 1'b1, 7'd63, 1'b1, 7'd7);
    idle(sweep_left);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'b00, 16'h0, 1'b1, 7'd63, 1'b1, 7'd70);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 2'b00, 16'h0, 1'b1, 7'd8, 1'b1, 7'd7);

    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 499) == 0, $urandom_range(0, 99) == 0,
                    $urandom_range(0, 1) == 1, randAddr(), 2'($urandom), 16'($urandom),
                    $urandom_range(0, 2) != 0, randAddr(),
                    $urandom_range(0, 2) != 0, randAddr());
    end
    idle(3);
    checkOutput("scoreboard drained", 16'(exp_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
